// File: rtl/mac_series_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative MAC series datapath among N requesters.
// Latches the winner's operand, launches the datapath, watchdogs the run and acks the winner.
module mac_series_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned RW      = 16,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  x_in,
  output logic [N-1:0]    ack,
  output logic [RW-1:0]   result_out,
  output logic            err,
  output logic            busy,
  output logic            dp_start,
  output logic [W-1:0]    dp_x,
  input  logic            dp_done,
  input  logic [RW-1:0]   dp_result
);

  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW  = IW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_gidx;
  logic [WDW-1:0]  r_wd;
  logic [N-1:0]    r_ack;
  logic [RW-1:0]   r_result;
  logic            r_err;
  logic            r_busy;
  logic            r_dp_start;
  logic [W-1:0]    r_dp_x;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [W-1:0]    w_x;
  logic            w_timeout;

  // First set request bit scanning ptr, ptr+1, ... modulo N.
  always_comb begin : pick
    logic [SW-1:0] v_sum;
    w_found = 1'b0;
    w_win   = '0;
    v_sum   = '0;
    for (int j = 0; j < int'(N); j++) begin
      v_sum = {1'b0, r_ptr} + SW'(j);
      if (v_sum >= SW'(N)) v_sum = v_sum - SW'(N);
      if (!w_found && req[v_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    w_x = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_win == IW'(i)) w_x = x_in[i*W +: W];
    end
  end

  assign w_timeout = (r_wd == WDW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT:   if (dp_done || w_timeout) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath registers; control outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_wd       <= '0;
      r_ack      <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_dp_start <= 1'b0;
      r_dp_x     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gidx <= w_win;
            r_dp_x <= w_x;
          end
        end
        S_LAUNCH: begin
          r_wd  <= '0;
          r_err <= 1'b0;
        end
        S_WAIT: begin
          r_wd <= r_wd + WDW'(1);
          if (dp_done) begin
            r_result <= dp_result;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        S_RESP: r_ptr <= (r_gidx == IW'(N - 1)) ? '0 : r_gidx + IW'(1);
        default: ;
      endcase
      r_dp_start <= (w_next == S_LAUNCH);
      r_busy     <= (w_next != S_IDLE);
      r_ack      <= (w_next == S_RESP) ? (N'(1) << r_gidx) : '0;
    end
  end

  assign ack        = r_ack;
  assign result_out = r_result;
  assign err        = r_err;
  assign busy       = r_busy;
  assign dp_start   = r_dp_start;
  assign dp_x       = r_dp_x;

endmodule

// File: tb/tb_mac_series_arbiter.sv
// Self-checking bench for mac_series_arbiter: datapath responder model plus expected-ack scoreboard.
module tb_mac_series_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  x_in = '0;
  logic [N-1:0]    ack;
  logic [RW-1:0]   result_out;
  logic            err;
  logic            busy;
  logic            dp_start;
  logic [W-1:0]    dp_x;
  logic            dp_done = 1'b0;
  logic [RW-1:0]   dp_result = '0;

  typedef struct packed {
    logic [N-1:0]  a;
    logic [RW-1:0] r;
    logic          e;
  } exp_t;

  exp_t          sbq[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            dp_delay = -1;
  logic [RW-1:0] dp_val = '0;
  int            n_starts = 0;

  mac_series_arbiter #(.N(N), .W(W), .RW(RW), .TIMEOUT(63)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .ack(ack),
    .result_out(result_out), .err(err), .busy(busy), .dp_start(dp_start),
    .dp_x(dp_x), .dp_done(dp_done), .dp_result(dp_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: answers dp_val ^ operand in WAIT cycle dp_delay (never if negative).
  always begin
    @(negedge clk);
    if (dp_start === 1'b1) begin
      n_starts++;
      if (dp_delay >= 0) begin
        repeat (dp_delay + 1) @(negedge clk);
        dp_done   = 1'b1;
        dp_result = dp_val ^ RW'(dp_x);
        @(negedge clk);
        dp_done   = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got none required finish");
    $fatal(1);
  end

  task automatic set_x(input int i, input logic [W-1:0] v);
    x_in[i*W +: W] = v;
  endtask

  task automatic wait_ack(input int lim, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; req = '0; x_in = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ack, err, busy, dp_start} !== '0) begin
      fails++; $display("FAIL reset_ctrl: got %b required 0", {ack, err, busy, dp_start});
    end
    tests++;
    if (result_out !== '0) begin
      fails++; $display("FAIL reset_result: got %h required 0", result_out);
    end
    tests++;
    if (dp_x !== '0) begin
      fails++; $display("FAIL reset_dpx: got %h required 0", dp_x);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_single;
    exp_t e; bit ok; int at; int t0; int s0;
    set_x(0, 8'h05); dp_val = 16'h0123 ^ 16'h0005; dp_delay = 1;
    sbq.push_back('{a: 4'b0001, r: 16'h0123, e: 1'b0});
    s0 = n_starts; t0 = cyc; req = 4'b0001;
    @(negedge clk);
    tests++;
    if (dp_start !== 1'b1 || dp_x !== 8'h05) begin
      fails++; $display("FAIL single_launch: got start=%b x=%h required start=1 x=05", dp_start, dp_x);
    end
    wait_ack(20, ok, at);
    e = sbq.pop_front();
    tests++;
    if (!ok) begin
      fails++; $display("FAIL single_ack_timeout: got no ack required %b", e.a);
    end
    tests++;
    if (at !== t0 + 4) begin
      fails++; $display("FAIL single_latency: got %0d required %0d", at - t0, 4);
    end
    tests++;
    if (ack !== e.a || result_out !== e.r || err !== e.e) begin
      fails++; $display("FAIL single_resp: got %b/%h/%b required %b/%h/%b", ack, result_out, err, e.a, e.r, e.e);
    end
    tests++;
    if (n_starts !== s0 + 1) begin
      fails++; $display("FAIL single_start_count: got %0d required %0d", n_starts - s0, 1);
    end
    req = '0;
    @(negedge clk);
    tests++;
    if (ack !== '0 || result_out !== 16'h0123) begin
      fails++; $display("FAIL single_hold: got ack=%b res=%h required ack=0 res=0123", ack, result_out);
    end
  endtask

  task automatic test_ptr;
    exp_t e; bit ok; int at;
    set_x(0, 8'h11); set_x(1, 8'h22); dp_val = 16'h3300; dp_delay = 0;
    sbq.push_back('{a: 4'b0010, r: 16'h3322, e: 1'b0});
    req = 4'b0011;
    wait_ack(20, ok, at);
    req = '0;
    e = sbq.pop_front();
    tests++;
    if (!ok || ack !== e.a || result_out !== e.r) begin
      fails++; $display("FAIL ptr_after_single: got %b/%h required %b/%h", ack, result_out, e.a, e.r);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    exp_t e; bit ok; int at;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    set_x(0, 8'h10); set_x(1, 8'h21); set_x(2, 8'h32); set_x(3, 8'h43);
    dp_val = 16'hBE00; dp_delay = 0;
    sbq.push_back('{a: 4'b0001, r: 16'hBE10, e: 1'b0});
    sbq.push_back('{a: 4'b0010, r: 16'hBE21, e: 1'b0});
    sbq.push_back('{a: 4'b0100, r: 16'hBE32, e: 1'b0});
    sbq.push_back('{a: 4'b1000, r: 16'hBE43, e: 1'b0});
    sbq.push_back('{a: 4'b0001, r: 16'hBE10, e: 1'b0});
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(20, ok, at);
      if (k == 4) req = '0;
      e = sbq.pop_front();
      tests++;
      if (!ok || ack !== e.a || result_out !== e.r || err !== e.e) begin
        fails++; $display("FAIL rr_grant%0d: got %b/%h/%b required %b/%h/%b", k, ack, result_out, err, e.a, e.r, e.e);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || ack !== '0) begin
        fails++; $display("FAIL rr_idle_gap%0d: got busy=%b ack=%b required busy=0 ack=0", k, busy, ack);
      end
      if (k < 4) begin
        @(negedge clk);
        tests++;
        if (dp_start !== 1'b1) begin
          fails++; $display("FAIL rr_relaunch%0d: got %b required 1", k, dp_start);
        end
      end
    end
  endtask

  task automatic test_timeout;
    exp_t e; bit ok; int at; int t0;
    set_x(2, 8'h77); dp_delay = -1;
    sbq.push_back('{a: 4'b0100, r: 16'h0000, e: 1'b1});
    t0 = cyc; req = 4'b0100;
    wait_ack(100, ok, at);
    req = '0;
    e = sbq.pop_front();
    tests++;
    if (!ok || at !== t0 + 66) begin
      fails++; $display("FAIL timeout_latency: got ok=%0d cycles=%0d required 66", ok, at - t0);
    end
    tests++;
    if (ack !== e.a || result_out !== e.r || err !== e.e) begin
      fails++; $display("FAIL timeout_resp: got %b/%h/%b required %b/%h/%b", ack, result_out, err, e.a, e.r, e.e);
    end
    @(negedge clk);
    dp_done = 1'b1; dp_result = 16'hFFFF;
    @(negedge clk);
    dp_done = 1'b0;
    tests++;
    if (result_out !== 16'h0000 || busy !== 1'b0 || ack !== '0) begin
      fails++; $display("FAIL late_done_ignored: got res=%h busy=%b ack=%b required 0000/0/0", result_out, busy, ack);
    end
  endtask

  task automatic test_done_at_timeout;
    exp_t e; bit ok; int at; int t0;
    set_x(2, 8'h77); dp_val = 16'h5A00; dp_delay = 63;
    sbq.push_back('{a: 4'b0100, r: 16'h5A77, e: 1'b0});
    t0 = cyc; req = 4'b0100;
    wait_ack(100, ok, at);
    req = '0;
    e = sbq.pop_front();
    tests++;
    if (!ok || at !== t0 + 66) begin
      fails++; $display("FAIL edge_latency: got ok=%0d cycles=%0d required 66", ok, at - t0);
    end
    tests++;
    if (ack !== e.a || result_out !== e.r || err !== e.e) begin
      fails++; $display("FAIL edge_done_wins: got %b/%h/%b required %b/%h/%b", ack, result_out, err, e.a, e.r, e.e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset;
    exp_t e; bit ok; int at; int t0;
    set_x(1, 8'h3C); dp_delay = -1;
    req = 4'b0010;
    repeat (6) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || dp_x !== 8'h3C) begin
      fails++; $display("FAIL areset_pre: got busy=%b x=%h required 1/3c", busy, dp_x);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({ack, err, busy, dp_start} !== '0 || result_out !== '0 || dp_x !== '0) begin
      fails++; $display("FAIL areset_outputs: got ack=%b err=%b busy=%b st=%b res=%h x=%h required all 0",
                        ack, err, busy, dp_start, result_out, dp_x);
    end
    dp_delay = 2; dp_val = 16'h1200;
    sbq.push_back('{a: 4'b0010, r: 16'h123C, e: 1'b0});
    @(negedge clk);
    rst = 1'b1; t0 = cyc;
    wait_ack(30, ok, at);
    req = '0;
    e = sbq.pop_front();
    tests++;
    if (!ok || at !== t0 + 5) begin
      fails++; $display("FAIL areset_recover_latency: got ok=%0d cycles=%0d required 5", ok, at - t0);
    end
    tests++;
    if (ack !== e.a || result_out !== e.r || err !== e.e) begin
      fails++; $display("FAIL areset_recover: got %b/%h/%b required %b/%h/%b", ack, result_out, err, e.a, e.r, e.e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e; bit ok; int at1; int at2; int t0; int s1;
    set_x(2, 8'h44); set_x(3, 8'h99); dp_val = 16'h0F00; dp_delay = 3;
    sbq.push_back('{a: 4'b0100, r: 16'h0F44, e: 1'b0});
    sbq.push_back('{a: 4'b1000, r: 16'h0F99, e: 1'b0});
    t0 = cyc; req = 4'b0100;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    req = 4'b1000;
    s1 = n_starts;
    wait_ack(30, ok, at1);
    e = sbq.pop_front();
    tests++;
    if (!ok || at1 !== t0 + 6 || ack !== e.a || result_out !== e.r) begin
      fails++; $display("FAIL drop_still_acked: got %b/%h at %0d required %b/%h at 6", ack, result_out, at1 - t0, e.a, e.r);
    end
    tests++;
    if (n_starts !== s1) begin
      fails++; $display("FAIL no_launch_while_busy: got %0d extra starts required 0", n_starts - s1);
    end
    wait_ack(30, ok, at2);
    req = '0;
    e = sbq.pop_front();
    tests++;
    if (!ok || at2 !== at1 + 7 || ack !== e.a || result_out !== e.r || err !== e.e) begin
      fails++; $display("FAIL late_req_served: got %b/%h gap %0d required %b/%h gap 7", ack, result_out, at2 - at1, e.a, e.r);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_ptr();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_async_reset();
    test_back_to_back();
    tests++;
    if (sbq.size() !== 0) begin
      fails++; $display("FAIL scoreboard_drain: got %0d left required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_series_arbiter.md
Name: mac_series_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one iterative multiply/accumulate series datapath among N requesters.
- The datapath is the x/t/r register unit with its own controller; it takes a start pulse plus operand and returns a done pulse plus result.
- This block latches the winning requester's operand, launches the datapath, and guards the run with a watchdog.
- It returns the result and a one-cycle ack to the winning requester.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand width per requester.
- RW, 16, datapath result width.
- TIMEOUT, 63, maximum WAIT cycles index before abort; watchdog width = clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request, level, held until ack.
- x_in  in  N*W  packed operands; slice i = x_in[i*W +: W], held stable while req[i] is high.
- ack  out  N  one-hot, one-cycle completion pulse to the served requester.
- result_out  out  RW  result of the last served transaction; valid with ack and held afterwards.
- err  out  1  high with ack when the transaction timed out.
- busy  out  1  high whenever state != IDLE.
- dp_start  out  1  one-cycle launch pulse to the datapath.
- dp_x  out  W  operand to the datapath; stable from LAUNCH through end of WAIT.
- dp_done  in  1  datapath completion pulse.
- dp_result  in  RW  datapath result, valid when dp_done = 1.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, priority pointer ptr = 0, watchdog = 0, gidx = 0.
  - Outputs: ack = 0, result_out = 0, err = 0, busy = 0, dp_start = 0, dp_x = 0.
  - Reset mid-transaction aborts it silently; no ack is issued.
- States: IDLE, LAUNCH, WAIT, RESP. Two-process FSM: a registered state plus combinational next-state logic. dp_x, result_out, err, gidx, ptr and watchdog are registers.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ... modulo N.
  - Latch gidx = winner and dp_x = x_in slice[winner]; go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: dp_start = 1 for exactly one cycle; watchdog cleared to 0; go to WAIT.
- WAIT:
  - watchdog increments each cycle.
  - dp_done = 1: latch result_out = dp_result, err = 0; go to RESP.
  - Else if watchdog == TIMEOUT: result_out = 0, err = 1; go to RESP.
  - dp_done in the same cycle as the timeout: done wins, err = 0.
  - WAIT lasts at most TIMEOUT+1 cycles.
- RESP:
  - ack[gidx] = 1 for one cycle; err is meaningful in this cycle only.
  - err is cleared back to 0 on the next transition into LAUNCH.
  - ptr = (gidx+1) mod N; go to IDLE.
- Latency: req sampled at edge k in IDLE gives LAUNCH in cycle k+1, WAIT from k+2. If dp_done arrives in cycle k+2+d, ack is in cycle k+3+d. Minimum req-to-ack is 3 cycles.
- req is sampled only in IDLE:
  - Changes to req or x_in while busy have no effect.
  - Dropping req after grant does not cancel; ack is still pulsed.
- dp_done received in IDLE, LAUNCH or RESP is ignored. result_out is unchanged.
- At most one transaction is outstanding. Back-to-back service returns to IDLE for one cycle, so new launches are at least 1 cycle apart from ack.
- Fairness: a requester that keeps req high is served within N transactions.

Test Plan:
- Reset, then req=0001, x0=8'h05, dp_done with dp_result=16'h0123 in the 2nd WAIT cycle:
  - dp_start pulses once with dp_x=05.
  - ack=0001 arrives 4 cycles after grant edge, result_out=0123, err=0, then ptr=1.
- req=1111 held, each run completes in 1 cycle: grants go 0,1,2,3,0 in order, with exactly one ack per transaction and a one-cycle IDLE gap between transactions.
- req=0100, no dp_done:
  - Exactly TIMEOUT+1 = 64 WAIT cycles, then ack=0100, err=1, result_out=0.
  - A late dp_done afterwards in IDLE is ignored.
- dp_done asserted in the same cycle watchdog reaches 63: err=0 and result_out = dp_result.
- rst driven low asynchronously mid-WAIT:
  - All outputs go to 0 immediately and ptr=0.
  - After release, req=0010 is served normally.
- req[2] dropped one cycle after grant: ack[2] still pulses. req[3] raised during WAIT is served only after return to IDLE.
